spi_slave_reg_ctrl: RTL and testbench



---
 rtl/spi_slave_reg_ctrl_pkg.sv | 30 +++
 rtl/spi_slave_reg_ctrl_if.sv | 45 ++++
 rtl/spi_slave_reg_ctrl_cs_sync_edge.sv | 35 +++
 rtl/spi_slave_reg_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_spi_slave_reg_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_reg_ctrl_pkg.sv
// Shared types and helpers for the SPI register command sequencer.
// Optional abort counter is enabled with the SPI_REG_CTRL_ERR_CNT_EN macro.
package spi_reg_ctrl_pkg;

    localparam int unsigned ADDR_W          = 7;
    localparam int unsigned CMD_RD_BIT      = 7;
    localparam logic [7:0]  STATUS_BYTE_DEF = 8'h5A;

    typedef enum logic [2:0] {
        StIdle,
        StPreload,
        StCmd,
        StWrite,
        StRdFetch,
        StRdCapture,
        StRdLoad,
        StRdWait
    } state_e;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] max_addr);
        return (addr == max_addr) ? '0 : addr + ADDR_W'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_clamp(input logic [ADDR_W-1:0] addr,
                                                     input logic [ADDR_W-1:0] max_addr);
        return (addr > max_addr) ? max_addr : addr;
    endfunction

endpackage

// File: rtl/spi_slave_reg_ctrl_if.sv
// Byte-stream, register-bank and status signals of the SPI register sequencer.
// SPI_REG_CTRL_ERR_CNT_EN adds the abort counter output and its clear input.
interface spi_slave_reg_ctrl_if;
    import spi_reg_ctrl_pkg::*;

    logic              i_SPI_CS_n;
    logic              i_RX_DV;
    logic [7:0]        i_RX_Byte;
    logic              i_MISO_ready;
    logic              o_TX_DV;
    logic [7:0]        o_TX_Byte;
    logic [ADDR_W-1:0] o_Reg_Addr;
    logic              o_Reg_Wr_En;
    logic [7:0]        o_Reg_Wr_Data;
    logic              o_Reg_Rd_En;
    logic [7:0]        i_Reg_Rd_Data;
    logic              o_Busy;
`ifdef SPI_REG_CTRL_ERR_CNT_EN
    logic              i_Err_Clr;
    logic [7:0]        o_Err_Cnt;

    modport slave (
        input  i_SPI_CS_n, i_RX_DV, i_RX_Byte, i_MISO_ready, i_Reg_Rd_Data, i_Err_Clr,
        output o_TX_DV, o_TX_Byte, o_Reg_Addr, o_Reg_Wr_En, o_Reg_Wr_Data, o_Reg_Rd_En,
               o_Busy, o_Err_Cnt
    );
    modport master (
        output i_SPI_CS_n, i_RX_DV, i_RX_Byte, i_MISO_ready, i_Reg_Rd_Data, i_Err_Clr,
        input  o_TX_DV, o_TX_Byte, o_Reg_Addr, o_Reg_Wr_En, o_Reg_Wr_Data, o_Reg_Rd_En,
               o_Busy, o_Err_Cnt
    );
`else
    modport slave (
        input  i_SPI_CS_n, i_RX_DV, i_RX_Byte, i_MISO_ready, i_Reg_Rd_Data,
        output o_TX_DV, o_TX_Byte, o_Reg_Addr, o_Reg_Wr_En, o_Reg_Wr_Data, o_Reg_Rd_En,
               o_Busy
    );
    modport master (
        output i_SPI_CS_n, i_RX_DV, i_RX_Byte, i_MISO_ready, i_Reg_Rd_Data,
        input  o_TX_DV, o_TX_Byte, o_Reg_Addr, o_Reg_Wr_En, o_Reg_Wr_Data, o_Reg_Rd_En,
               o_Busy
    );
`endif

endinterface

// File: rtl/spi_slave_reg_ctrl_cs_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pad input with rise/fall pulses
// derived from the synchronized level.
module cs_sync_edge #(
    parameter int unsigned Stages   = 2,
    parameter logic        ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [Stages-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[Stages-2:0], d_i};
        prev_d = sync_q[Stages-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {Stages{ResetVal}};
            prev_q <= ResetVal;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q[Stages-1] & ~prev_q;
    assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/spi_slave_reg_ctrl.sv
// Per-frame command decoder streaming auto-incrementing register reads/writes over SPI bytes.
// Define SPI_REG_CTRL_ERR_CNT_EN to count frames aborted before their TX byte was loaded.
module spi_slave_reg_ctrl
    import spi_reg_ctrl_pkg::*;
#(
    parameter int unsigned MAX_ADDR    = 127,
    parameter logic [7:0]  STATUS_BYTE = STATUS_BYTE_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                 i_Clk,
    input logic                 i_Rst,
    spi_slave_reg_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] MaxAddr = ADDR_W'(MAX_ADDR);

    logic cs_rise, cs_fall;

    // Synchronizer resets to "selected" so CS held low through reset never fakes a new frame.
    cs_sync_edge #(
        .Stages   (SYNC_STAGES),
        .ResetVal (1'b0)
    ) u_cs_sync (
        .clk_i  (i_Clk),
        .rst_i  (i_Rst),
        .d_i    (bus.i_SPI_CS_n),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic              busy_q, busy_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              rd_en_q, rd_en_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] cmd_addr;

    assign cmd_addr = addr_clamp(bus.i_RX_Byte[ADDR_W-1:0], MaxAddr);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        reg_addr_d = reg_addr_q;
        busy_d     = busy_q;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        rd_en_d    = 1'b0;
        rd_data_d  = rd_data_q;

        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StPreload;
                    busy_d  = 1'b1;
                end
            end
            StPreload: begin
                if (bus.i_MISO_ready) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = STATUS_BYTE;
                    state_d   = StCmd;
                end
            end
            StCmd: begin
                if (bus.i_RX_DV) begin
                    addr_d = cmd_addr;
                    if (bus.i_RX_Byte[CMD_RD_BIT]) begin
                        // Read strobe is issued on entry so data lands during StRdCapture.
                        rd_en_d    = 1'b1;
                        reg_addr_d = cmd_addr;
                        state_d    = StRdFetch;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (bus.i_RX_DV) begin
                    wr_en_d    = 1'b1;
                    wr_data_d  = bus.i_RX_Byte;
                    reg_addr_d = addr_q;
                    addr_d     = addr_inc(addr_q, MaxAddr);
                end
            end
            StRdFetch: state_d = StRdCapture;
            StRdCapture: begin
                rd_data_d = bus.i_Reg_Rd_Data;
                state_d   = StRdLoad;
            end
            StRdLoad: begin
                if (bus.i_MISO_ready) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = rd_data_q;
                    addr_d    = addr_inc(addr_q, MaxAddr);
                    state_d   = StRdWait;
                end
            end
            StRdWait: begin
                if (bus.i_RX_DV) begin
                    rd_en_d    = 1'b1;
                    reg_addr_d = addr_q;
                    state_d    = StRdFetch;
                end
            end
            default: state_d = StIdle;
        endcase

        // A write already accepted in this cycle still commits; everything else is dropped.
        if (cs_rise) begin
            state_d   = StIdle;
            busy_d    = 1'b0;
            tx_dv_d   = 1'b0;
            tx_byte_d = tx_byte_q;
            rd_en_d   = 1'b0;
        end
    end

`ifdef SPI_REG_CTRL_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.i_Err_Clr) begin
            err_cnt_d = '0;
        end else if (cs_rise && err_cnt_q != 8'hFF &&
                     (state_q inside {StPreload, StCmd, StRdFetch, StRdCapture, StRdLoad})) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    assign bus.o_Err_Cnt = err_cnt_q;
`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            reg_addr_q <= '0;
            busy_q     <= 1'b0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 8'h00;
            rd_en_q    <= 1'b0;
            rd_data_q  <= 8'h00;
`ifdef SPI_REG_CTRL_ERR_CNT_EN
            err_cnt_q  <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            reg_addr_q <= reg_addr_d;
            busy_q     <= busy_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            rd_en_q    <= rd_en_d;
            rd_data_q  <= rd_data_d;
`ifdef SPI_REG_CTRL_ERR_CNT_EN
            err_cnt_q  <= err_cnt_d;
`endif
        end
    end

    assign bus.o_TX_DV       = tx_dv_q;
    assign bus.o_TX_Byte     = tx_byte_q;
    assign bus.o_Reg_Addr    = reg_addr_q;
    assign bus.o_Reg_Wr_En   = wr_en_q;
    assign bus.o_Reg_Wr_Data = wr_data_q;
    assign bus.o_Reg_Rd_En   = rd_en_q;
    assign bus.o_Busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Directed-sequence bench with random data for spi_slave_reg_ctrl; a register-bank model
// answers reads and expected traffic is derived from the command/address rules.
module tb_spi_slave_reg_ctrl;

    localparam int MaxAddr = 127;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_reg_ctrl_if bus ();

    spi_slave_reg_ctrl u_dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int tx_bad = 0;

    logic [7:0] mem [128];
    bit         mem_init = 1'b0;
    logic [7:0] tx_q[$];
    logic [7:0] wr_d_q[$];
    int         wr_a_q[$];
    int         rd_q[$];
    bit         rd_pend = 1'b0;
    int         rd_paddr = 0;

    logic [7:0] stim[$];
    int         wr_base, rd_base, tx_base;

    // Register bank and traffic monitor; read data is valid only in the cycle after Rd_En.
    always @(posedge clk) begin
        #1;
        if (!mem_init) begin
            foreach (mem[i]) mem[i] = 8'($urandom);
            mem_init = 1'b1;
        end
        bus.i_Reg_Rd_Data = rd_pend ? mem[rd_paddr] : 8'($urandom);
        rd_pend = 1'b0;
        if (bus.o_Reg_Rd_En) begin
            rd_pend  = 1'b1;
            rd_paddr = int'(bus.o_Reg_Addr);
            rd_q.push_back(int'(bus.o_Reg_Addr));
        end
        if (bus.o_Reg_Wr_En) begin
            mem[bus.o_Reg_Addr] = bus.o_Reg_Wr_Data;
            wr_a_q.push_back(int'(bus.o_Reg_Addr));
            wr_d_q.push_back(bus.o_Reg_Wr_Data);
        end
        if (bus.o_TX_DV) begin
            tx_q.push_back(bus.o_TX_Byte);
            if (!bus.i_MISO_ready) tx_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int a, input int i);
        return (a + i) % (MaxAddr + 1);
    endfunction

    function automatic logic [31:0] tx_at(input int i);
        return (tx_base + i < tx_q.size()) ? 32'(tx_q[tx_base + i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] rd_at(input int i);
        return (rd_base + i < rd_q.size()) ? 32'(rd_q[rd_base + i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] wr_a_at(input int i);
        return (wr_base + i < wr_a_q.size()) ? 32'(wr_a_q[wr_base + i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] wr_d_at(input int i);
        return (wr_base + i < wr_d_q.size()) ? 32'(wr_d_q[wr_base + i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.i_RX_DV   = 1'b1;
        bus.i_RX_Byte = b;
        @(negedge clk);
        bus.i_RX_DV   = 1'b0;
        cyc(10);
    endtask

    task automatic cs_low();
        wr_base = wr_a_q.size();
        rd_base = rd_q.size();
        tx_base = tx_q.size();
        @(negedge clk);
        bus.i_SPI_CS_n = 1'b0;
        cyc(8);
    endtask

    task automatic cs_high();
        @(negedge clk);
        bus.i_SPI_CS_n = 1'b1;
        cyc(8);
    endtask

    task automatic rand_stim(input int n);
        stim.delete();
        repeat (n) stim.push_back(8'($urandom));
    endtask

    task automatic write_body(input int a);
        cs_low();
        send(8'(a));
        foreach (stim[i]) send(stim[i]);
    endtask

    task automatic check_writes(input string tag, input int a);
        check({tag, " nwr"}, 32'(wr_a_q.size() - wr_base), 32'(stim.size()));
        for (int i = 0; i < stim.size(); i++) begin
            check($sformatf("%s wr%0d addr", tag, i), wr_a_at(i), 32'(nxt(a, i)));
            check($sformatf("%s wr%0d data", tag, i), wr_d_at(i), 32'(stim[i]));
        end
    endtask

    task automatic read_frame(input string tag, input int a, input int k);
        cs_low();
        send(8'h80 | 8'(a));
        repeat (k) send(8'($urandom));
        cs_high();
        check({tag, " ntx"}, 32'(tx_q.size() - tx_base), 32'(k + 2));
        check({tag, " tx status"}, tx_at(0), 32'h5A);
        check({tag, " nrd"}, 32'(rd_q.size() - rd_base), 32'(k + 1));
        for (int i = 0; i <= k; i++) begin
            check($sformatf("%s rd%0d addr", tag, i), rd_at(i), 32'(nxt(a, i)));
            check($sformatf("%s tx%0d", tag, i + 1), tx_at(i + 1), 32'(mem[nxt(a, i)]));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " tx_dv"}, 32'(bus.o_TX_DV), 32'h0);
        check({tag, " tx_byte"}, 32'(bus.o_TX_Byte), 32'h0);
        check({tag, " addr"}, 32'(bus.o_Reg_Addr), 32'h0);
        check({tag, " wr_en"}, 32'(bus.o_Reg_Wr_En), 32'h0);
        check({tag, " wr_data"}, 32'(bus.o_Reg_Wr_Data), 32'h0);
        check({tag, " rd_en"}, 32'(bus.o_Reg_Rd_En), 32'h0);
        check({tag, " busy"}, 32'(bus.o_Busy), 32'h0);
`ifdef SPI_REG_CTRL_ERR_CNT_EN
        check({tag, " err_cnt"}, 32'(bus.o_Err_Cnt), 32'h0);
`endif
    endtask

    initial begin
        int a;
        bus.i_SPI_CS_n   = 1'b1;
        bus.i_RX_DV      = 1'b0;
        bus.i_RX_Byte    = 8'h00;
        bus.i_MISO_ready = 1'b1;
`ifdef SPI_REG_CTRL_ERR_CNT_EN
        bus.i_Err_Clr    = 1'b0;
`endif
        cyc(3);
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        cyc(4);

        // Plan write frame, including Busy release latency after CS rises.
        stim.delete();
        stim.push_back(8'hAA);
        stim.push_back(8'hBB);
        write_body(5);
        check("wr busy", 32'(bus.o_Busy), 32'h1);
        @(negedge clk);
        bus.i_SPI_CS_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("busy after 2", 32'(bus.o_Busy), 32'h1);
        @(posedge clk);
        #1 check("busy after 3", 32'(bus.o_Busy), 32'h0);
        cyc(6);
        check_writes("wr_plan", 5);

        // Random-address write burst.
        a = int'($urandom_range(0, MaxAddr));
        rand_stim(4);
        write_body(a);
        cs_high();
        check_writes("wr_rand", a);

        // Plan read: load 0x10/0x11 through the DUT, then read them back.
        stim.delete();
        stim.push_back(8'h11);
        stim.push_back(8'h22);
        write_body(8'h10);
        cs_high();
        check_writes("wr_0x10", 8'h10);
        read_frame("rd_plan", 8'h10, 2);
        check("rd_plan tx1 lit", tx_at(1), 32'h11);
        check("rd_plan tx2 lit", tx_at(2), 32'h22);

        // Address wrap on writes and reads.
        rand_stim(2);
        write_body(MaxAddr);
        cs_high();
        check_writes("wr_wrap", MaxAddr);
        read_frame("rd_wrap", int'($urandom_range(124, MaxAddr)), 4);

        // Backpressure while a read byte waits to be loaded.
        a = int'($urandom_range(0, MaxAddr));
        cs_low();
        bus.i_MISO_ready = 1'b0;
        send(8'h80 | 8'(a));
        cyc(10);
        check("bp held ntx", 32'(tx_q.size() - tx_base), 32'd1);
        check("bp nrd", 32'(rd_q.size() - rd_base), 32'd1);
        @(negedge clk);
        bus.i_MISO_ready = 1'b1;
        cyc(3);
        check("bp released ntx", 32'(tx_q.size() - tx_base), 32'd2);
        check("bp data", tx_at(1), 32'(mem[a]));
        cyc(5);
        check("bp single pulse", 32'(tx_q.size() - tx_base), 32'd2);
        cs_high();

        // Abort between read strobe and TX load.
        a = int'($urandom_range(0, MaxAddr));
        cs_low();
        bus.i_MISO_ready = 1'b0;
        send(8'h80 | 8'(a));
        cs_high();
        bus.i_MISO_ready = 1'b1;
        cyc(6);
        check("abort busy", 32'(bus.o_Busy), 32'h0);
        check("abort ntx", 32'(tx_q.size() - tx_base), 32'd1);
        check("abort nrd", 32'(rd_q.size() - rd_base), 32'd1);
`ifdef SPI_REG_CTRL_ERR_CNT_EN
        check("abort err_cnt", 32'(bus.o_Err_Cnt), 32'd1);
        @(negedge clk);
        bus.i_Err_Clr = 1'b1;
        @(negedge clk);
        bus.i_Err_Clr = 1'b0;
        check("err clear", 32'(bus.o_Err_Cnt), 32'd0);
`endif

        // Reset in the middle of a write frame, right as a write strobe is up.
        cs_low();
        send(8'h20);
        @(negedge clk);
        bus.i_RX_DV   = 1'b1;
        bus.i_RX_Byte = 8'($urandom_range(1, 255));
        @(negedge clk);
        bus.i_RX_DV = 1'b0;
        check("pre-rst wr_en", 32'(bus.o_Reg_Wr_En), 32'h1);
        rst = 1'b1;
        #1 check_idle_outputs("mid rst");
        check("mid rst nwr", 32'(wr_a_q.size() - wr_base), 32'd1);
        check("mid rst wr addr", wr_a_at(0), 32'h20);
        @(negedge clk);
        rst = 1'b0;
        send(8'h33);
        send(8'h44);
        check("post rst nwr", 32'(wr_a_q.size() - wr_base), 32'd1);
        check("post rst nrd", 32'(rd_q.size() - rd_base), 32'd0);
        check("post rst busy", 32'(bus.o_Busy), 32'h0);
        cs_high();
        a = int'($urandom_range(0, MaxAddr));
        rand_stim(2);
        write_body(a);
        cs_high();
        check_writes("wr_after_rst", a);

        check("tx while not ready", 32'(tx_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
